// File: rtl/regdisp_nchan.sv
// regdisp_nchan
//   Register dispatcher on the reg_native_if bus. One upstream request is
//   decoded against FORWARD_NUM base/size windows. It is forwarded, with
//   its address rebased, to exactly one downstream channel. The single
//   outstanding transaction is tracked until that channel acks.
//   Unmapped or illegal requests (wr_en == rd_en) get a local error
//   response. soft_rst is broadcast to every channel and aborts a pending
//   transaction without an upstream ack.
//
// Ports
//   regdisp_nchan_clk / regdisp_nchan_rst_n : clock, async active-low reset
//   upstream__regdisp_nchan__*              : upstream request
//                                             (req_vld, addr, wr_en, rd_en,
//                                              wr_data, soft_rst)
//   regdisp_nchan__upstream__*              : upstream response
//                                             (ack_vld, err, rd_data)
//   regdisp_nchan__downstream__*            : per-channel request, packed
//                                             channel k at [k*W +: W]
//   downstream__regdisp_nchan__*            : per-channel response, packed
//
// Configuration
//   REGDISP_NCHAN_TIMEOUT_EN : when defined, a 16-bit WAIT counter returns
//                              an error response after TIMEOUT_CYCLES cycles
//                              without an ack from the selected channel.
module regdisp_nchan #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int FORWARD_NUM = 4,
    parameter logic [FORWARD_NUM*ADDR_WIDTH-1:0] BASE_ADDR = {FORWARD_NUM{{ADDR_WIDTH{1'b0}}}},
    parameter logic [FORWARD_NUM*ADDR_WIDTH-1:0] WIN_SIZE  = {FORWARD_NUM{ADDR_WIDTH'(64'h200)}},
    parameter logic [FORWARD_NUM-1:0] INSERT_FORWARD_FF = '0,
    parameter int INSERT_BACKWARD_FF = 0,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                              regdisp_nchan_clk,
    input  logic                              regdisp_nchan_rst_n,
    input  logic                              upstream__regdisp_nchan__req_vld,
    input  logic [ADDR_WIDTH-1:0]             upstream__regdisp_nchan__addr,
    input  logic                              upstream__regdisp_nchan__wr_en,
    input  logic                              upstream__regdisp_nchan__rd_en,
    input  logic [DATA_WIDTH-1:0]             upstream__regdisp_nchan__wr_data,
    input  logic                              upstream__regdisp_nchan__soft_rst,
    output logic                              regdisp_nchan__upstream__ack_vld,
    output logic                              regdisp_nchan__upstream__err,
    output logic [DATA_WIDTH-1:0]             regdisp_nchan__upstream__rd_data,
    output logic [FORWARD_NUM-1:0]            regdisp_nchan__downstream__req_vld,
    output logic [FORWARD_NUM*ADDR_WIDTH-1:0] regdisp_nchan__downstream__addr,
    output logic [FORWARD_NUM-1:0]            regdisp_nchan__downstream__wr_en,
    output logic [FORWARD_NUM-1:0]            regdisp_nchan__downstream__rd_en,
    output logic [FORWARD_NUM*DATA_WIDTH-1:0] regdisp_nchan__downstream__wr_data,
    output logic [FORWARD_NUM-1:0]            regdisp_nchan__downstream__soft_rst,
    input  logic [FORWARD_NUM-1:0]            downstream__regdisp_nchan__ack_vld,
    input  logic [FORWARD_NUM-1:0]            downstream__regdisp_nchan__err,
    input  logic [FORWARD_NUM*DATA_WIDTH-1:0] downstream__regdisp_nchan__rd_data
);

    // state      | meaning
    // ST_IDLE    | no transaction outstanding, accepting requests
    // ST_WAIT    | request forwarded to channel sel_q, waiting for its ack
    // ST_ERR_RSP | driving the local error response for a bad request
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR_RSP} state_t;

    localparam int SEL_W = (FORWARD_NUM > 1) ? $clog2(FORWARD_NUM) : 1;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    is_wr_q, is_wr_d;
    logic                    hit;
    logic [SEL_W-1:0]        hit_idx;
    logic [ADDR_WIDTH-1:0]   hit_off;
    logic                    accept;
    logic                    rsp_vld_d, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_data_d;

    wire up_req  = upstream__regdisp_nchan__req_vld;
    wire up_srst = upstream__regdisp_nchan__soft_rst;
    wire up_wr   = upstream__regdisp_nchan__wr_en;
    wire up_rd   = upstream__regdisp_nchan__rd_en;

    // Window decode. The offset is taken first and compared against the
    // size, so base+size never has to be formed and cannot overflow.
    always_comb begin
        logic [ADDR_WIDTH-1:0] base_k;
        logic [ADDR_WIDTH-1:0] off_k;
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        base_k  = '0;
        off_k   = '0;
        for (int k = 0; k < FORWARD_NUM; k++) begin
            base_k = BASE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
            off_k  = upstream__regdisp_nchan__addr - base_k;
            if (!hit && (upstream__regdisp_nchan__addr >= base_k) &&
                (off_k < WIN_SIZE[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
                hit_off = off_k;
            end
        end
    end

    // A request in the same cycle as soft_rst is dropped entirely.
    assign accept = (state_q == ST_IDLE) && up_req && !up_srst && (up_wr ^ up_rd) && hit;

`ifdef REGDISP_NCHAN_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        is_wr_d    = is_wr_q;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (up_req && !up_srst) begin
                    if (accept) begin
                        state_d = ST_WAIT;
                        sel_d   = hit_idx;
                        is_wr_d = up_wr;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_ERR_RSP;
                    end
                end
            end
            ST_ERR_RSP: begin
                state_d = ST_IDLE;
                if (!up_srst) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (up_srst) begin
                    state_d = ST_IDLE;
                end else if (downstream__regdisp_nchan__ack_vld[sel_q]) begin
                    // The channel's ack beats a coincident timeout.
                    state_d    = ST_IDLE;
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = downstream__regdisp_nchan__err[sel_q];
                    rsp_data_d = is_wr_q ? '0 :
                                 downstream__regdisp_nchan__rd_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                end
`ifdef REGDISP_NCHAN_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles, so this fires on
                // WAIT cycle number TIMEOUT_CYCLES.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge regdisp_nchan_clk or negedge regdisp_nchan_rst_n) begin
        if (!regdisp_nchan_rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            is_wr_q <= 1'b0;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            is_wr_q <= is_wr_d;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Per-channel forward path, optionally registered.
    for (genvar k = 0; k < FORWARD_NUM; k++) begin : g_ch
        logic                  fwd_req_d, fwd_wr_d, fwd_rd_d;
        logic [ADDR_WIDTH-1:0] fwd_addr_d;
        logic [DATA_WIDTH-1:0] fwd_wdata_d;

        assign fwd_req_d   = accept && (hit_idx == SEL_W'(k));
        assign fwd_wr_d    = fwd_req_d & up_wr;
        assign fwd_rd_d    = fwd_req_d & up_rd;
        assign fwd_addr_d  = fwd_req_d ? hit_off : '0;
        assign fwd_wdata_d = fwd_req_d ? upstream__regdisp_nchan__wr_data : '0;

        if (INSERT_FORWARD_FF[k]) begin : g_ff
            logic                  fwd_req_q, fwd_wr_q, fwd_rd_q, fwd_srst_q;
            logic [ADDR_WIDTH-1:0] fwd_addr_q;
            logic [DATA_WIDTH-1:0] fwd_wdata_q;
            always_ff @(posedge regdisp_nchan_clk or negedge regdisp_nchan_rst_n) begin
                if (!regdisp_nchan_rst_n) begin
                    fwd_req_q   <= 1'b0;
                    fwd_wr_q    <= 1'b0;
                    fwd_rd_q    <= 1'b0;
                    fwd_srst_q  <= 1'b0;
                    fwd_addr_q  <= '0;
                    fwd_wdata_q <= '0;
                end else begin
                    fwd_req_q   <= fwd_req_d;
                    fwd_wr_q    <= fwd_wr_d;
                    fwd_rd_q    <= fwd_rd_d;
                    fwd_srst_q  <= up_srst;
                    fwd_addr_q  <= fwd_addr_d;
                    fwd_wdata_q <= fwd_wdata_d;
                end
            end
            assign regdisp_nchan__downstream__req_vld[k]  = fwd_req_q;
            assign regdisp_nchan__downstream__wr_en[k]    = fwd_wr_q;
            assign regdisp_nchan__downstream__rd_en[k]    = fwd_rd_q;
            assign regdisp_nchan__downstream__soft_rst[k] = fwd_srst_q;
            assign regdisp_nchan__downstream__addr[k*ADDR_WIDTH +: ADDR_WIDTH]    = fwd_addr_q;
            assign regdisp_nchan__downstream__wr_data[k*DATA_WIDTH +: DATA_WIDTH] = fwd_wdata_q;
        end else begin : g_direct
            assign regdisp_nchan__downstream__req_vld[k]  = fwd_req_d;
            assign regdisp_nchan__downstream__wr_en[k]    = fwd_wr_d;
            assign regdisp_nchan__downstream__rd_en[k]    = fwd_rd_d;
            assign regdisp_nchan__downstream__soft_rst[k] = up_srst;
            assign regdisp_nchan__downstream__addr[k*ADDR_WIDTH +: ADDR_WIDTH]    = fwd_addr_d;
            assign regdisp_nchan__downstream__wr_data[k*DATA_WIDTH +: DATA_WIDTH] = fwd_wdata_d;
        end
    end

    // Upstream response, optionally registered.
    if (INSERT_BACKWARD_FF != 0) begin : g_bwd_ff
        logic                  rsp_vld_q, rsp_err_q;
        logic [DATA_WIDTH-1:0] rsp_data_q;
        always_ff @(posedge regdisp_nchan_clk or negedge regdisp_nchan_rst_n) begin
            if (!regdisp_nchan_rst_n) begin
                rsp_vld_q  <= 1'b0;
                rsp_err_q  <= 1'b0;
                rsp_data_q <= '0;
            end else begin
                rsp_vld_q  <= rsp_vld_d;
                rsp_err_q  <= rsp_err_d;
                rsp_data_q <= rsp_data_d;
            end
        end
        assign regdisp_nchan__upstream__ack_vld = rsp_vld_q;
        assign regdisp_nchan__upstream__err     = rsp_err_q;
        assign regdisp_nchan__upstream__rd_data = rsp_data_q;
    end else begin : g_bwd_direct
        assign regdisp_nchan__upstream__ack_vld = rsp_vld_d;
        assign regdisp_nchan__upstream__err     = rsp_err_d;
        assign regdisp_nchan__upstream__rd_data = rsp_data_d;
    end

endmodule

// File: tb/tb_regdisp_nchan.sv
// Directed bench for regdisp_nchan. dut0 has no pipeline stages and
// TIMEOUT_CYCLES=8. dut1 registers channel 1's forward path and the
// upstream response. Inputs change on the falling edge, and outputs are
// sampled 1 ns later.
module tb_regdisp_nchan;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam logic [N*AW-1:0] BASE = {64'h2000, 64'h1000, 64'h0400, 64'h0000};
    localparam logic [N*AW-1:0] SIZE = {4{64'h200}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    logic          req0, wr0, rd0, srst0, ack0, err0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic [N-1:0]  dreq0, dwr0, drd0, dsrst0, dack0, derr0;
    logic [N*AW-1:0] daddr0;
    logic [N*DW-1:0] dwdata0, drdata0;

    logic          req1, wr1, rd1, srst1, ack1, err1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic [N-1:0]  dreq1, dwr1, drd1, dsrst1, dack1, derr1;
    logic [N*AW-1:0] daddr1;
    logic [N*DW-1:0] dwdata1, drdata1;

    regdisp_nchan #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FORWARD_NUM(N),
        .BASE_ADDR(BASE), .WIN_SIZE(SIZE), .INSERT_FORWARD_FF(4'b0000),
        .INSERT_BACKWARD_FF(0), .TIMEOUT_CYCLES(8)) dut0 (
        .regdisp_nchan_clk(clk), .regdisp_nchan_rst_n(rst_n),
        .upstream__regdisp_nchan__req_vld(req0), .upstream__regdisp_nchan__addr(addr0),
        .upstream__regdisp_nchan__wr_en(wr0), .upstream__regdisp_nchan__rd_en(rd0),
        .upstream__regdisp_nchan__wr_data(wdata0), .upstream__regdisp_nchan__soft_rst(srst0),
        .regdisp_nchan__upstream__ack_vld(ack0), .regdisp_nchan__upstream__err(err0),
        .regdisp_nchan__upstream__rd_data(rdata0),
        .regdisp_nchan__downstream__req_vld(dreq0), .regdisp_nchan__downstream__addr(daddr0),
        .regdisp_nchan__downstream__wr_en(dwr0), .regdisp_nchan__downstream__rd_en(drd0),
        .regdisp_nchan__downstream__wr_data(dwdata0), .regdisp_nchan__downstream__soft_rst(dsrst0),
        .downstream__regdisp_nchan__ack_vld(dack0), .downstream__regdisp_nchan__err(derr0),
        .downstream__regdisp_nchan__rd_data(drdata0));

    regdisp_nchan #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FORWARD_NUM(N),
        .BASE_ADDR(BASE), .WIN_SIZE(SIZE), .INSERT_FORWARD_FF(4'b0010),
        .INSERT_BACKWARD_FF(1), .TIMEOUT_CYCLES(255)) dut1 (
        .regdisp_nchan_clk(clk), .regdisp_nchan_rst_n(rst_n),
        .upstream__regdisp_nchan__req_vld(req1), .upstream__regdisp_nchan__addr(addr1),
        .upstream__regdisp_nchan__wr_en(wr1), .upstream__regdisp_nchan__rd_en(rd1),
        .upstream__regdisp_nchan__wr_data(wdata1), .upstream__regdisp_nchan__soft_rst(srst1),
        .regdisp_nchan__upstream__ack_vld(ack1), .regdisp_nchan__upstream__err(err1),
        .regdisp_nchan__upstream__rd_data(rdata1),
        .regdisp_nchan__downstream__req_vld(dreq1), .regdisp_nchan__downstream__addr(daddr1),
        .regdisp_nchan__downstream__wr_en(dwr1), .regdisp_nchan__downstream__rd_en(drd1),
        .regdisp_nchan__downstream__wr_data(dwdata1), .regdisp_nchan__downstream__soft_rst(dsrst1),
        .downstream__regdisp_nchan__ack_vld(dack1), .downstream__regdisp_nchan__err(derr1),
        .downstream__regdisp_nchan__rd_data(drdata1));

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0 = 0; wr0 = 0; rd0 = 0; srst0 = 0; dack0 = '0; derr0 = '0;
        req1 = 0; wr1 = 0; rd1 = 0; srst1 = 0; dack1 = '0; derr1 = '0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (ack0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== '0) begin fails++; $display("FAIL reset_up0 ack=%b err=%b rd=%h exp 0", ack0, err0, rdata0); end
        tests_run++; if (dreq0 !== 4'b0 || daddr0 !== '0 || dsrst0 !== 4'b0) begin fails++; $display("FAIL reset_dn0 req=%b srst=%b exp 0", dreq0, dsrst0); end
        tests_run++; if (ack1 !== 1'b0 || dreq1 !== 4'b0 || dsrst1 !== 4'b0) begin fails++; $display("FAIL reset_dut1 ack=%b req=%b srst=%b exp 0", ack1, dreq1, dsrst1); end
    endtask

    task automatic test_read_basic();
        cyc(); req0 = 1; rd0 = 1; addr0 = 64'h1104; #1;
        tests_run++; if (dreq0 !== 4'b0100) begin fails++; $display("FAIL rd_req got=%b exp=0100", dreq0); end
        tests_run++; if (daddr0[2*AW +: AW] !== 64'h104) begin fails++; $display("FAIL rd_addr got=%h exp=104", daddr0[2*AW +: AW]); end
        tests_run++; if (drd0 !== 4'b0100 || dwr0 !== 4'b0000) begin fails++; $display("FAIL rd_en got rd=%b wr=%b exp 0100/0000", drd0, dwr0); end
        tests_run++; if (daddr0[0 +: AW] !== '0) begin fails++; $display("FAIL rd_nonsel_addr got=%h exp=0", daddr0[0 +: AW]); end
        cyc(); req0 = 0; rd0 = 0; #1;
        tests_run++; if (dreq0 !== 4'b0000) begin fails++; $display("FAIL rd_pulse got=%b exp=0000", dreq0); end
        cyc(); #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rd_early_ack got=%b exp=0", ack0); end
        cyc(); dack0[2] = 1; drdata0[2*DW +: DW] = 32'hA5A5_0001; #1;
        tests_run++; if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hA5A5_0001) begin fails++; $display("FAIL rd_rsp got ack=%b err=%b rd=%h exp 1/0/a5a50001", ack0, err0, rdata0); end
        cyc(); dack0 = '0; #1;
        tests_run++; if (ack0 !== 1'b0 || rdata0 !== '0) begin fails++; $display("FAIL rd_rsp_end got ack=%b rd=%h exp 0/0", ack0, rdata0); end
    endtask

    task automatic test_err_rsp();
        cyc(); req0 = 1; wr0 = 1; addr0 = 64'h9000; wdata0 = 32'h1111_2222; #1;
        tests_run++; if (dreq0 !== 4'b0 || ack0 !== 1'b0) begin fails++; $display("FAIL unmap_req got req=%b ack=%b exp 0/0", dreq0, ack0); end
        cyc(); req0 = 0; wr0 = 0; #1;
        tests_run++; if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== '0) begin fails++; $display("FAIL unmap_rsp got ack=%b err=%b rd=%h exp 1/1/0", ack0, err0, rdata0); end
        cyc(); #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL unmap_end got=%b exp=0", ack0); end
        cyc(); req0 = 1; wr0 = 1; rd0 = 1; addr0 = 64'h1104; #1;
        tests_run++; if (dreq0 !== 4'b0) begin fails++; $display("FAIL wrrd_req got=%b exp=0000", dreq0); end
        cyc(); req0 = 0; wr0 = 0; rd0 = 0; #1;
        tests_run++; if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== '0) begin fails++; $display("FAIL wrrd_rsp got ack=%b err=%b rd=%h exp 1/1/0", ack0, err0, rdata0); end
        cyc(); #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL wrrd_end got=%b exp=0", ack0); end
    endtask

    task automatic test_pipeline_ff();
        cyc(); req1 = 1; wr1 = 1; addr1 = 64'h0410; wdata1 = 32'h1234_5678; #1;
        tests_run++; if (dreq1 !== 4'b0) begin fails++; $display("FAIL ff_req_early got=%b exp=0000", dreq1); end
        cyc(); req1 = 0; wr1 = 0; #1;
        tests_run++; if (dreq1 !== 4'b0010 || dwr1 !== 4'b0010) begin fails++; $display("FAIL ff_req got req=%b wr=%b exp 0010/0010", dreq1, dwr1); end
        tests_run++; if (daddr1[AW +: AW] !== 64'h10 || dwdata1[DW +: DW] !== 32'h1234_5678) begin fails++; $display("FAIL ff_payload got addr=%h wd=%h exp 10/12345678", daddr1[AW +: AW], dwdata1[DW +: DW]); end
        cyc(); #1;
        tests_run++; if (dreq1 !== 4'b0) begin fails++; $display("FAIL ff_pulse got=%b exp=0000", dreq1); end
        cyc(); dack1[1] = 1; drdata1[DW +: DW] = 32'hFFFF_FFFF; #1;
        tests_run++; if (ack1 !== 1'b0) begin fails++; $display("FAIL ff_ack_early got=%b exp=0", ack1); end
        cyc(); dack1 = '0; #1;
        tests_run++; if (ack1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== '0) begin fails++; $display("FAIL ff_rsp got ack=%b err=%b rd=%h exp 1/0/0", ack1, err1, rdata1); end
        cyc(); #1;
        tests_run++; if (ack1 !== 1'b0) begin fails++; $display("FAIL ff_rsp_end got=%b exp=0", ack1); end
        // Error response through the backward stage lands two cycles after the request.
        cyc(); req1 = 1; rd1 = 1; addr1 = 64'h8000; #1;
        cyc(); req1 = 0; rd1 = 0; #1;
        tests_run++; if (ack1 !== 1'b0) begin fails++; $display("FAIL ff_err_early got=%b exp=0", ack1); end
        cyc(); #1;
        tests_run++; if (ack1 !== 1'b1 || err1 !== 1'b1) begin fails++; $display("FAIL ff_err_rsp got ack=%b err=%b exp 1/1", ack1, err1); end
        // Soft reset: channel 1 registered, others direct.
        cyc(); srst1 = 1; #1;
        tests_run++; if (dsrst1 !== 4'b1101) begin fails++; $display("FAIL ff_srst got=%b exp=1101", dsrst1); end
        cyc(); srst1 = 0; #1;
        tests_run++; if (dsrst1 !== 4'b0010) begin fails++; $display("FAIL ff_srst_late got=%b exp=0010", dsrst1); end
    endtask

    task automatic test_wait_ignore();
        cyc(); req0 = 1; rd0 = 1; addr0 = 64'h0008; #1;
        tests_run++; if (dreq0 !== 4'b0001 || daddr0[0 +: AW] !== 64'h8) begin fails++; $display("FAIL wi_req got req=%b addr=%h exp 0001/8", dreq0, daddr0[0 +: AW]); end
        cyc(); req0 = 0; rd0 = 0; #1;
        cyc(); dack0[3] = 1; drdata0[3*DW +: DW] = 32'h0000_DEAD; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL wi_other_ack got=%b exp=0", ack0); end
        cyc(); dack0 = '0; req0 = 1; rd0 = 1; addr0 = 64'h2000; #1;
        tests_run++; if (dreq0 !== 4'b0 || ack0 !== 1'b0) begin fails++; $display("FAIL wi_second_req got req=%b ack=%b exp 0/0", dreq0, ack0); end
        cyc(); req0 = 0; rd0 = 0; dack0[0] = 1; derr0[0] = 1; drdata0[0 +: DW] = 32'h55; #1;
        tests_run++; if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h55) begin fails++; $display("FAIL wi_rsp got ack=%b err=%b rd=%h exp 1/1/55", ack0, err0, rdata0); end
        cyc(); dack0 = '0; derr0 = '0; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL wi_end got=%b exp=0", ack0); end
    endtask

    task automatic test_timeout();
        cyc(); req0 = 1; rd0 = 1; addr0 = 64'h1000; drdata0[2*DW +: DW] = 32'hBAD0_BAD0; #1;
        cyc(); req0 = 0; rd0 = 0; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_wait1 got=%b exp=0", ack0); end
        for (int i = 2; i <= 7; i++) begin
            cyc(); #1;
            tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_wait%0d got=%b exp=0", i, ack0); end
        end
        cyc(); #1;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
        tests_run++; if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== '0) begin fails++; $display("FAIL to_fire got ack=%b err=%b rd=%h exp 1/1/0", ack0, err0, rdata0); end
`else
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_none got=%b exp=0", ack0); end
`endif
        cyc(); #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_after got=%b exp=0", ack0); end
        cyc(); dack0[2] = 1; #1;
`ifdef REGDISP_NCHAN_TIMEOUT_EN
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_late_ack got=%b exp=0", ack0); end
`else
        tests_run++; if (ack0 !== 1'b1 || rdata0 !== 32'hBAD0_BAD0) begin fails++; $display("FAIL to_ack got ack=%b rd=%h exp 1/bad0bad0", ack0, rdata0); end
`endif
        cyc(); dack0 = '0; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL to_end got=%b exp=0", ack0); end
    endtask

    task automatic test_soft_rst();
        cyc(); req0 = 1; rd0 = 1; addr0 = 64'h0404; #1;
        cyc(); req0 = 0; rd0 = 0; #1;
        cyc(); srst0 = 1; #1;
        tests_run++; if (dsrst0 !== 4'b1111 || ack0 !== 1'b0) begin fails++; $display("FAIL sr_bcast got srst=%b ack=%b exp 1111/0", dsrst0, ack0); end
        cyc(); srst0 = 0; dack0[1] = 1; drdata0[DW +: DW] = 32'h99; #1;
        tests_run++; if (ack0 !== 1'b0 || dsrst0 !== 4'b0) begin fails++; $display("FAIL sr_idle_ack got ack=%b srst=%b exp 0/0000", ack0, dsrst0); end
        cyc(); dack0 = '0; req0 = 1; rd0 = 1; addr0 = 64'h0404; #1;
        tests_run++; if (dreq0 !== 4'b0010 || daddr0[AW +: AW] !== 64'h4) begin fails++; $display("FAIL sr_next_req got req=%b addr=%h exp 0010/4", dreq0, daddr0[AW +: AW]); end
        cyc(); req0 = 0; rd0 = 0; dack0[1] = 1; drdata0[DW +: DW] = 32'h77; #1;
        tests_run++; if (ack0 !== 1'b1 || rdata0 !== 32'h77) begin fails++; $display("FAIL sr_next_rsp got ack=%b rd=%h exp 1/77", ack0, rdata0); end
        cyc(); dack0 = '0; req0 = 1; wr0 = 1; srst0 = 1; addr0 = 64'h1000; #1;
        tests_run++; if (dreq0 !== 4'b0) begin fails++; $display("FAIL sr_drop_req got=%b exp=0000", dreq0); end
        cyc(); req0 = 0; wr0 = 0; srst0 = 0; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL sr_drop_ack got=%b exp=0", ack0); end
    endtask

    task automatic test_hw_reset_wait();
        cyc(); req0 = 1; rd0 = 1; addr0 = 64'h1008; #1;
        cyc(); req0 = 0; rd0 = 0; #1;
        rst_n = 0; #1;
        tests_run++; if (ack0 !== 1'b0 || dreq0 !== 4'b0) begin fails++; $display("FAIL hr_in_reset got ack=%b req=%b exp 0/0000", ack0, dreq0); end
        cyc(); rst_n = 1;
        cyc(); dack0[2] = 1; drdata0[2*DW +: DW] = 32'h4242; #1;
        tests_run++; if (ack0 !== 1'b0) begin fails++; $display("FAIL hr_no_ack got=%b exp=0", ack0); end
        cyc(); dack0 = '0; #1;
    endtask

    initial begin
        idle_inputs();
        addr0 = '0; wdata0 = '0; drdata0 = '0;
        addr1 = '0; wdata1 = '0; drdata1 = '0;
        test_reset();
        cyc(); cyc(); rst_n = 1;
        test_reset();
        test_read_basic();
        test_err_rsp();
        test_pipeline_ff();
        test_wait_ignore();
        test_timeout();
        test_soft_rst();
        test_hw_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
